// File: rtl/datapath_p_pkg.sv
// Shared definitions for datapath_p: op codes, flag bit positions,
// sequential-unit operation kinds and the link-register index.
package datapath_p_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_CMP = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam logic [3:0] OP_LD  = 4'd12;
    localparam logic [3:0] OP_ST  = 4'd13;
    localparam logic [3:0] OP_JAL = 4'd14;
    localparam logic [3:0] OP_NOP = 4'd15;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

    typedef enum logic [1:0] {
        SEQ_SLL,
        SEQ_SRL,
        SEQ_SRA,
        SEQ_MUL
    } seq_kind_e;

    function automatic int link_reg(input int regs);
        return regs - 2;
    endfunction

endpackage

// File: rtl/dp_seq_unit.sv
// Multi-cycle unit: one-bit-per-cycle shifts and, with DATAPATH_P_MUL_EN
// defined, an iterative shift-add multiply sharing the same counter.
module dp_seq_unit
    import datapath_p_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  seq_kind_e            i_kind,
    input  logic [W-1:0]         i_a,
`ifdef DATAPATH_P_MUL_EN
    input  logic [W-1:0]         i_b,
`endif
    input  logic [$clog2(W)-1:0] i_amt,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [W-1:0]         o_result,
    output logic                 o_carry,
    output logic                 o_set_c
);

    localparam int CW = $clog2(W) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    seq_kind_e     kind_q, kind_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  step_val;
    logic          step_bit;
`ifdef DATAPATH_P_MUL_EN
    logic [W-1:0]  opb_q, opb_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  acc_step;
`endif

    // One shift step; the multiplicand advances with the SLL step too.
    always_comb begin
        step_val = {opa_q[W-2:0], 1'b0};
        step_bit = opa_q[W-1];
        case (kind_q)
            SEQ_SRL: begin
                step_val = {1'b0, opa_q[W-1:1]};
                step_bit = opa_q[0];
            end
            SEQ_SRA: begin
                step_val = {opa_q[W-1], opa_q[W-1:1]};
                step_bit = opa_q[0];
            end
            default: ;
        endcase
    end

`ifdef DATAPATH_P_MUL_EN
    assign acc_step = acc_q + (opb_q[0] ? opa_q : '0);
`endif

    // NOTE: every next-state variable gets its hold value first so no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        kind_d = kind_q;
        opa_d  = opa_q;
`ifdef DATAPATH_P_MUL_EN
        opb_d  = opb_q;
        acc_d  = acc_q;
`endif
        if (i_start) begin
            kind_d = i_kind;
            opa_d  = i_a;
            cnt_d  = CW'(i_amt);
`ifdef DATAPATH_P_MUL_EN
            opb_d  = i_b;
            acc_d  = '0;
            if (i_kind == SEQ_MUL) cnt_d = CW'(W);
`endif
        end else if (o_busy) begin
            cnt_d = cnt_q - CW'(1);
            opa_d = step_val;
`ifdef DATAPATH_P_MUL_EN
            opb_d = opb_q >> 1;
            acc_d = acc_step;
`endif
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked block; state uses <= only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            kind_q <= SEQ_SLL;
            opa_q  <= '0;
`ifdef DATAPATH_P_MUL_EN
            opb_q  <= '0;
            acc_q  <= '0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
            opa_q  <= opa_d;
`ifdef DATAPATH_P_MUL_EN
            opb_q  <= opb_d;
            acc_q  <= acc_d;
`endif
        end
    end

    assign o_busy  = (cnt_q != '0);
    assign o_done  = (cnt_q == CW'(1));
    assign o_carry = step_bit;
    assign o_set_c = (kind_q != SEQ_MUL);
`ifdef DATAPATH_P_MUL_EN
    assign o_result = (kind_q == SEQ_MUL) ? acc_step : step_val;
`else
    assign o_result = step_val;
`endif

endmodule

// File: rtl/datapath_p.sv
// Parametrised core datapath: PC, register file, NZCV flags, single-cycle ALU
// and a multi-cycle shift unit (multiply added when DATAPATH_P_MUL_EN is defined).
module datapath_p
    import datapath_p_pkg::*;
#(
    parameter int             W       = 16,
    parameter int             REGS    = 16,
    parameter logic [W-1:0]   RST_VEC = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_exec_ce,
    input  logic [3:0]              i_op,
    input  logic [$clog2(REGS)-1:0] i_rd,
    input  logic [$clog2(REGS)-1:0] i_rs,
    input  logic [W-1:0]            i_imm,
    input  logic                    i_use_imm,
    input  logic                    i_we,
    input  logic                    i_br_taken,
    input  logic [W-1:0]            i_br_off,
    input  logic                    i_irq_take,
    input  logic [W-1:0]            i_irq_vector,
    input  logic [W-1:0]            i_data_in,
    output logic [W-1:0]            o_i_ad,
    output logic [W-1:0]            o_d_ad,
    output logic [W-1:0]            o_data_out,
    output logic                    o_d_we,
    output logic                    o_busy,
    output logic                    o_ccz,
    output logic                    o_ccn,
    output logic                    o_ccc,
    output logic                    o_ccv
);

    localparam int              RW      = $clog2(REGS);
    localparam int              SW      = $clog2(W);
    localparam logic [RW-1:0]   LINK    = RW'(link_reg(REGS));
    localparam logic [W-1:0]    PC_STEP = W'(2);

    logic [W-1:0]  rf_q [REGS];
    logic [W-1:0]  pc_q, pc_d;
    logic [3:0]    flags_q, flags_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          we_q, we_d;

    logic [W-1:0]  op_a, op_b, rs_val, res;
    logic [SW-1:0] shamt;
    logic          accept, irq;
    logic          sub_op, add_cin, add_v, set_zn;
    logic [W-1:0]  add_b;
    logic [W:0]    add_sum;
    logic          wr_en;
    logic [RW-1:0] wr_addr;

    logic          seq_start, seq_busy, seq_done, seq_carry, seq_set_c;
    seq_kind_e     seq_kind;
    logic [W-1:0]  seq_result;

    assign op_a   = rf_q[i_rd];
    assign rs_val = rf_q[i_rs];
    assign op_b   = i_use_imm ? i_imm : rs_val;
    assign shamt  = op_b[SW-1:0];

    // Interrupt entry outranks a same-cycle instruction; neither is taken while busy.
    assign irq    = i_irq_take && !seq_busy && !i_rst;
    assign accept = i_exec_ce && !seq_busy && !i_irq_take && !i_rst;

    // Subtraction is A + ~B + cin, so carry out means "no borrow".
    assign sub_op = (i_op == OP_SUB) || (i_op == OP_SBC) || (i_op == OP_CMP);
    assign add_b  = sub_op ? ~op_b : op_b;

    always_comb begin
        add_cin = 1'b0;
        case (i_op)
            OP_SUB, OP_CMP: add_cin = 1'b1;
            OP_ADC, OP_SBC: add_cin = flags_q[FLAG_C];
            default:        ;
        endcase
    end

    assign add_sum = {1'b0, op_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    assign add_v   = (op_a[W-1] == add_b[W-1]) && (add_sum[W-1] != op_a[W-1]);

    always_comb begin
        pc_d      = pc_q;
        flags_d   = flags_q;
        rd_d      = rd_q;
        we_d      = we_q;
        res       = '0;
        set_zn    = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = i_rd;
        seq_start = 1'b0;
        seq_kind  = SEQ_SLL;

        if (seq_done) begin
            res     = seq_result;
            wr_en   = we_q;
            wr_addr = rd_q;
            set_zn  = 1'b1;
            if (seq_set_c) flags_d[FLAG_C] = seq_carry;
        end else if (irq) begin
            pc_d    = i_irq_vector;
            res     = pc_q;
            wr_en   = 1'b1;
            wr_addr = LINK;
        end else if (accept) begin
            pc_d = i_br_taken ? pc_q + i_br_off : pc_q + PC_STEP;
            case (i_op)
                OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP: begin
                    res             = add_sum[W-1:0];
                    wr_en           = i_we && (i_op != OP_CMP);
                    set_zn          = 1'b1;
                    flags_d[FLAG_C] = add_sum[W];
                    flags_d[FLAG_V] = add_v;
                end
                OP_AND: begin res = op_a & op_b; wr_en = i_we; set_zn = 1'b1; end
                OP_OR:  begin res = op_a | op_b; wr_en = i_we; set_zn = 1'b1; end
                OP_XOR: begin res = op_a ^ op_b; wr_en = i_we; set_zn = 1'b1; end
                OP_SLL, OP_SRL, OP_SRA: begin
                    if (shamt == '0) begin
                        res             = op_a;
                        wr_en           = i_we;
                        set_zn          = 1'b1;
                        flags_d[FLAG_C] = 1'b0;
                    end else begin
                        seq_start = 1'b1;
                        seq_kind  = (i_op == OP_SLL) ? SEQ_SLL :
                                    (i_op == OP_SRL) ? SEQ_SRL : SEQ_SRA;
                        rd_d      = i_rd;
                        we_d      = i_we;
                    end
                end
`ifdef DATAPATH_P_MUL_EN
                OP_MUL: begin
                    seq_start = 1'b1;
                    seq_kind  = SEQ_MUL;
                    rd_d      = i_rd;
                    we_d      = i_we;
                end
`else
                OP_MUL: ;
`endif
                OP_LD:  begin res = i_data_in; wr_en = i_we; end
                OP_JAL: begin
                    res   = pc_q + PC_STEP;
                    wr_en = 1'b1;
                    pc_d  = rs_val + i_imm;
                end
                OP_ST, OP_NOP: ;
                default: ;
            endcase
        end

        if (set_zn) begin
            flags_d[FLAG_Z] = (res == '0);
            flags_d[FLAG_N] = res[W-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q    <= RST_VEC;
            flags_q <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flags_q <= flags_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
        end
    end

    // NOTE: the register file is a plain memory and is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_rst) rf_q[wr_addr] <= res;
    end

    dp_seq_unit #(
        .W (W)
    ) u_seq (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (seq_start),
        .i_kind   (seq_kind),
        .i_a      (op_a),
`ifdef DATAPATH_P_MUL_EN
        .i_b      (op_b),
`endif
        .i_amt    (shamt),
        .o_busy   (seq_busy),
        .o_done   (seq_done),
        .o_result (seq_result),
        .o_carry  (seq_carry),
        .o_set_c  (seq_set_c)
    );

    assign o_i_ad     = pc_q;
    assign o_d_ad     = rs_val + i_imm;
    assign o_data_out = op_a;
    assign o_d_we     = accept && (i_op == OP_ST);
    assign o_busy     = seq_busy;
    assign o_ccz      = flags_q[FLAG_Z];
    assign o_ccn      = flags_q[FLAG_N];
    assign o_ccc      = flags_q[FLAG_C];
    assign o_ccv      = flags_q[FLAG_V];

endmodule

// File: tb/tb_datapath_p.sv
// Self-checking bench for datapath_p: directed scenarios with literal
// expectations, then random instructions compared against a behavioural model.
module tb_datapath_p;

    localparam logic [3:0] ADD = 0, SUB = 1, ADC = 2, SBC = 3, CMP = 4, AND_ = 5,
                           OR_ = 6, XOR_ = 7, SLL = 8, SRL = 9, SRA = 10, MUL = 11,
                           LD = 12, ST = 13, JAL = 14, NOP = 15;

    logic        clk = 1'b0;
    logic        i_rst, i_exec_ce, i_use_imm, i_we, i_br_taken, i_irq_take;
    logic [3:0]  i_op, i_rd, i_rs;
    logic [15:0] i_imm, i_br_off, i_irq_vector, i_data_in;
    logic [15:0] o_i_ad, o_d_ad, o_data_out;
    logic        o_d_we, o_busy, o_ccz, o_ccn, o_ccc, o_ccv;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state
    logic [15:0] m_rf [16];
    bit          m_rv [16];
    logic [15:0] m_pc;
    bit          m_z, m_n, m_c, m_v;
    int          m_busy;
    logic [3:0]  p_rd;
    bit          p_we, p_setc, p_c;
    logic [15:0] p_res;

    datapath_p #(
        .W       (16),
        .REGS    (16),
        .RST_VEC (16'h0100)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_exec_ce    (i_exec_ce),
        .i_op         (i_op),
        .i_rd         (i_rd),
        .i_rs         (i_rs),
        .i_imm        (i_imm),
        .i_use_imm    (i_use_imm),
        .i_we         (i_we),
        .i_br_taken   (i_br_taken),
        .i_br_off     (i_br_off),
        .i_irq_take   (i_irq_take),
        .i_irq_vector (i_irq_vector),
        .i_data_in    (i_data_in),
        .o_i_ad       (o_i_ad),
        .o_d_ad       (o_d_ad),
        .o_data_out   (o_data_out),
        .o_d_we       (o_d_we),
        .o_busy       (o_busy),
        .o_ccz        (o_ccz),
        .o_ccn        (o_ccn),
        .o_ccc        (o_ccc),
        .o_ccv        (o_ccv)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit oflow(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    task automatic m_write(input logic [3:0] r, input logic [15:0] v);
        m_rf[r] = v;
        m_rv[r] = 1'b1;
    endtask

    // Next state of the architecture for one clock edge, from the current inputs.
    task automatic model_step();
        logic [15:0] a, b, r, tgt;
        int ua, ub, sa, sb, t, k, cin;
        if (i_rst) begin
            m_pc = 16'h0100;
            {m_z, m_n, m_c, m_v} = 4'b0000;
            m_busy = 0;
            return;
        end
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                if (p_we) m_write(p_rd, p_res);
                m_z = (p_res == 16'h0000);
                m_n = p_res[15];
                if (p_setc) m_c = p_c;
            end
            return;
        end
        if (i_irq_take) begin
            m_write(4'd14, m_pc);
            m_pc = i_irq_vector;
            return;
        end
        if (!i_exec_ce) return;
        a   = m_rf[i_rd];
        b   = i_use_imm ? i_imm : m_rf[i_rs];
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        cin = m_c ? 1 : 0;
        tgt = m_rf[i_rs] + i_imm;
        m_pc = i_br_taken ? m_pc + i_br_off : m_pc + 16'd2;
        case (i_op)
            ADD, SUB, CMP, ADC, SBC: begin
                case (i_op)
                    ADD:     begin t = ua + ub;           m_c = (t > 65535); m_v = oflow(sa + sb); end
                    ADC:     begin t = ua + ub + cin;     m_c = (t > 65535); m_v = oflow(sa + sb + cin); end
                    SBC:     begin t = ua - ub - 1 + cin; m_c = (t >= 0);    m_v = oflow(sa - sb - 1 + cin); end
                    default: begin t = ua - ub;           m_c = (t >= 0);    m_v = oflow(sa - sb); end
                endcase
                r = 16'(t);
                m_z = (r == 0);
                m_n = r[15];
                if (i_we && i_op != CMP) m_write(i_rd, r);
            end
            AND_, OR_, XOR_: begin
                r = (i_op == AND_) ? (a & b) : (i_op == OR_) ? (a | b) : (a ^ b);
                m_z = (r == 0);
                m_n = r[15];
                if (i_we) m_write(i_rd, r);
            end
            SLL, SRL, SRA: begin
                k = int'(b[3:0]);
                if (k == 0) begin
                    m_z = (a == 0);
                    m_n = a[15];
                    m_c = 1'b0;
                    if (i_we) m_write(i_rd, a);
                end else begin
                    if (i_op == SLL) begin p_res = a << k; p_c = a[16-k]; end
                    else if (i_op == SRL) begin p_res = a >> k; p_c = a[k-1]; end
                    else begin p_res = 16'($signed(a) >>> k); p_c = a[k-1]; end
                    p_rd = i_rd; p_we = i_we; p_setc = 1'b1;
                    m_busy = k;
                end
            end
`ifdef DATAPATH_P_MUL_EN
            MUL: begin
                p_res = 16'(longint'(ua) * longint'(ub));
                p_rd = i_rd; p_we = i_we; p_setc = 1'b0;
                m_busy = 16;
            end
`endif
            LD:  if (i_we) m_write(i_rd, i_data_in);
            JAL: begin
                m_write(i_rd, m_pc_plus2_prev(tgt));
                m_pc = tgt;
            end
            default: ;
        endcase
    endtask

    // JAL links the address of the instruction after itself; m_pc was already advanced.
    function automatic logic [15:0] m_pc_plus2_prev(input logic [15:0] unused_tgt);
        logic [15:0] dummy;
        dummy = unused_tgt;
        return i_br_taken ? m_pc - i_br_off + 16'd2 : m_pc;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic exec(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [15:0] imm, input bit use_imm, input bit we);
        i_op = op; i_rd = rd; i_rs = rs; i_imm = imm; i_use_imm = use_imm; i_we = we;
        i_exec_ce = 1'b1;
        tick();
        i_exec_ce = 1'b0;
    endtask

    task automatic ld(input logic [3:0] r, input logic [15:0] v);
        i_data_in = v;
        exec(LD, r, 4'd0, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic peek(input logic [3:0] r, input logic [15:0] exp, input string name);
        i_exec_ce = 1'b0; i_irq_take = 1'b0; i_rd = r;
        #1;
        check(name, o_data_out, exp);
    endtask

    task automatic count_busy(output int n_busy);
        n_busy = 0;
        for (int n = 0; n < 40 && o_busy === 1'b1; n++) begin
            n_busy++;
            tick();
            i_exec_ce = 1'b0;
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("pc", o_i_ad, m_pc);
            check("flags_zncv", {o_ccz, o_ccn, o_ccc, o_ccv}, {m_z, m_n, m_c, m_v});
            check("busy", o_busy, (m_busy != 0));
            check("d_we", o_d_we, !i_rst && i_exec_ce && !i_irq_take && (m_busy == 0) && (i_op == ST));
            if (m_rv[i_rd]) check("data_out", o_data_out, m_rf[i_rd]);
            if (m_rv[i_rs]) check("d_ad", o_d_ad, 16'(m_rf[i_rs] + i_imm));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        i_rst = 1'b1; i_exec_ce = 1'b0; i_op = NOP; i_rd = 0; i_rs = 0; i_imm = 0;
        i_use_imm = 1'b0; i_we = 1'b0; i_br_taken = 1'b0; i_br_off = 0;
        i_irq_take = 1'b0; i_irq_vector = 0; i_data_in = 0;
        m_busy = 0;
        tick();
        tick();
        i_rst = 1'b0;

        check("reset_pc", o_i_ad, 16'h0100);
        check("reset_flags", {o_ccz, o_ccn, o_ccc, o_ccv}, 4'b0000);
        check("reset_busy", o_busy, 1'b0);
        cmp_en = 1'b1;

        for (int r = 0; r < 16; r++) ld(4'(r), 16'($urandom));
        check("pc_after_init", o_i_ad, 16'h0120);

        // Signed overflow on ADD
        ld(4'd1, 16'h7FFF);
        ld(4'd2, 16'h0001);
        exec(ADD, 4'd1, 4'd2, 16'h0000, 1'b0, 1'b1);
        check("add_flags", {o_ccz, o_ccn, o_ccc, o_ccv}, 4'b0101);
        check("add_pc", o_i_ad, 16'h0126);
        peek(4'd1, 16'h8000, "add_result");

        // SUB to zero, then SBC with carry in
        ld(4'd1, 16'h0005);
        exec(SUB, 4'd1, 4'd0, 16'h0005, 1'b1, 1'b1);
        check("sub_flags", {o_ccz, o_ccn, o_ccc, o_ccv}, 4'b1010);
        exec(SBC, 4'd1, 4'd0, 16'h0000, 1'b1, 1'b1);
        check("sbc_flags", {o_ccz, o_ccn, o_ccc, o_ccv}, 4'b1010);
        peek(4'd1, 16'h0000, "sbc_result");

        // Zero-amount shift completes immediately and clears C
        ld(4'd4, 16'h8000);
        exec(SLL, 4'd4, 4'd0, 16'h0000, 1'b1, 1'b1);
        check("sll0_busy", o_busy, 1'b0);
        check("sll0_flags", {o_ccz, o_ccn, o_ccc, o_ccv}, 4'b0100);
        peek(4'd4, 16'h8000, "sll0_result");

        // Four-cycle arithmetic shift with an ignored instruction while busy
        ld(4'd3, 16'h8001);
        exec(SRA, 4'd3, 4'd0, 16'h0004, 1'b1, 1'b1);
        i_op = ADD; i_rd = 4'd3; i_rs = 4'd3; i_imm = 16'h0001; i_use_imm = 1'b1; i_we = 1'b1;
        i_exec_ce = 1'b1;
        count_busy(nb);
        check("sra_busy_cycles", nb, 4);
        check("sra_flags", {o_ccz, o_ccn, o_ccc, o_ccv}, 4'b0100);
        peek(4'd3, 16'hF800, "sra_result");

        // Store strobe in the accept cycle
        ld(4'd2, 16'h0001);
        i_op = ST; i_rd = 4'd1; i_rs = 4'd2; i_imm = 16'h0004; i_exec_ce = 1'b1;
        #1;
        check("st_we", o_d_we, 1'b1);
        check("st_addr", o_d_ad, 16'h0005);
        tick();
        i_exec_ce = 1'b0;

        // Interrupt entry beats a same-cycle instruction
        ld(4'd5, 16'h1234);
        i_br_taken = 1'b1;
        i_br_off = 16'h0200 - m_pc;
        exec(NOP, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0);
        i_br_taken = 1'b0;
        check("branch_pc", o_i_ad, 16'h0200);
        i_irq_take = 1'b1; i_irq_vector = 16'h0040;
        i_op = ADD; i_rd = 4'd5; i_rs = 4'd0; i_imm = 16'h0001; i_use_imm = 1'b1; i_we = 1'b1;
        i_exec_ce = 1'b1;
        tick();
        i_irq_take = 1'b0; i_exec_ce = 1'b0;
        check("irq_pc", o_i_ad, 16'h0040);
        peek(4'd14, 16'h0200, "irq_link");
        peek(4'd5, 16'h1234, "irq_blocked_insn");

`ifdef DATAPATH_P_MUL_EN
        ld(4'd6, 16'h0012);
        ld(4'd7, 16'h0034);
        exec(MUL, 4'd6, 4'd7, 16'h0000, 1'b0, 1'b1);
        count_busy(nb);
        check("mul_busy_cycles", nb, 16);
        peek(4'd6, 16'h03A8, "mul_result");
        ld(4'd6, 16'h0012);
        exec(MUL, 4'd6, 4'd7, 16'h0000, 1'b0, 1'b1);
        for (int n = 0; n < 4; n++) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("mul_abort_busy", o_busy, 1'b0);
        check("mul_abort_pc", o_i_ad, 16'h0100);
        peek(4'd6, 16'h0012, "mul_abort_no_wb");
`endif

        // Random instruction stream
        for (int n = 0; n < 3000; n++) begin
            i_rst        = ($urandom_range(0, 199) == 0);
            i_exec_ce    = !i_rst && ($urandom_range(0, 3) != 0);
            i_op         = 4'($urandom);
            i_rd         = 4'($urandom);
            i_rs         = 4'($urandom);
            i_imm        = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            i_use_imm    = 1'($urandom);
            i_we         = ($urandom_range(0, 3) != 0);
            i_br_taken   = ($urandom_range(0, 3) == 0);
            i_br_off     = 16'($urandom) & 16'hFFFE;
            i_irq_take   = !i_rst && ($urandom_range(0, 24) == 0);
            i_irq_vector = 16'($urandom) & 16'hFFFE;
            i_data_in    = 16'($urandom);
            tick();
        end

        i_rst = 1'b0; i_exec_ce = 1'b0; i_irq_take = 1'b0; i_br_taken = 1'b0;
        for (int n = 0; n < 20; n++) tick();
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/datapath_p.md
# datapath_p

Parametrised successor to the 16-bit core datapath. It holds the PC, an N-entry register file, NZCV flags and a single-cycle adder/logic path. It adds a multi-cycle sequential unit for variable shifts (and optionally multiply) with a stall output. It sits between the instruction decoder, which presents an encoded op, and the fetch/memory buses.

## Interface
- W, 16, data/address width (≥8, power of 2)
- REGS, 16, register count (power of 2, ≥4); link register is index REGS-2
- RST_VEC, 0, PC value after reset
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock, reset is synchronous and active-high
- i_exec_ce  in  1  instruction valid; accepted when high and o_busy low
- i_op  in  4  encoded op (see Operation)
- i_rd, i_rs  in  $clog2(REGS)  destination/A and source/B register indices
- i_imm  in  W  pre-extended immediate
- i_use_imm  in  1  B operand = i_imm instead of R[rs]
- i_we  in  1  writeback enable for result ops
- i_br_taken  in  1  branch taken with current accept
- i_br_off  in  W  byte offset added to PC on taken branch
- i_irq_take  in  1  interrupt entry, honoured only when o_busy low
- i_irq_vector  in  W  interrupt target
- i_data_in  in  W  load data, valid in the accept cycle
- o_i_ad  out  W  fetch address = PC register
- o_d_ad  out  W  R[rs]+i_imm
- o_data_out  out  W  R[rd]
- o_d_we  out  1  store strobe (combinational, accept cycle)
- o_busy  out  1  sequential unit occupied
- o_ccz, o_ccn, o_ccc, o_ccv  out  1 each  flags

## Operation
- Operands: A = R[rd], B = i_use_imm ? i_imm : R[rs]. Register file is 2R1W, not reset, write-first not required.
- Op codes:
  - 0 ADD, 1 SUB (A−B), 2 ADC (A+B+C), 3 SBC (A+~B+C), 4 CMP (SUB, no writeback)
  - 5 AND, 6 OR, 7 XOR
  - 8 SLL, 9 SRL, 10 SRA; amount = B[$clog2(W)-1:0]
  - 11 MUL
  - 12 LD (R[rd]←i_data_in)
  - 13 ST (o_d_we=1)
  - 14 JAL (R[rd]←PC+2, PC←R[rs]+i_imm)
  - 15 NOP
- Writeback occurs only if i_we, except JAL, which always writes back.
- Flags:
  - Arithmetic ops 0–4 set Z, N, C, V. C = carry-out of the adder; subtract computes A+~B+1, so C=1 means no borrow. V = signed overflow.
  - Logic ops set Z and N; C and V hold.
  - Shifts set Z and N; C = last bit shifted out, or 0 if amount is 0; V holds.
  - MUL sets Z and N. LD, ST, JAL and NOP leave flags unchanged.
- PC on accept:
  - JAL: PC ← R[rs]+i_imm.
  - i_br_taken: PC ← PC+i_br_off.
  - Otherwise: PC ← PC+2.
  - The PC update happens at accept, including for multi-cycle ops. Upstream holds the next instruction while o_busy is high.
- i_irq_take with o_busy low has priority over i_exec_ce: PC ← i_irq_vector and R[REGS-2] ← PC. Any same-cycle instruction is not accepted.
- Sequential unit (shifts and MUL):
  - Shift with amount 0 completes in the accept cycle, with writeback and flags applied.
  - Shift with amount k>0 sets o_busy for k cycles, shifting 1 bit per cycle. Result and flags are written on the clock edge ending the last busy cycle, using rd and i_we latched at accept.
- Reset mid-operation clears o_busy and aborts the op with no writeback and no flag update.

## Timing
- Reset values: PC=RST_VEC, flags 0, o_busy 0, o_d_we 0, sequential state cleared.
- Single-cycle ops: result, flags and PC are visible the cycle after accept.
- o_busy rises the cycle after accept and falls the cycle after completion writeback. i_exec_ce and i_irq_take are ignored while o_busy is high.

## Configuration
- DATAPATH_P_MUL_EN defined: op 11 is an iterative shift-add multiply. o_busy is held for W cycles and the low W bits of A×B are written, with Z and N set.
- Undefined: op 11 behaves as NOP (no busy, no writeback, flags hold). The multiplier logic is absent.

## Structure
- Shared package datapath_p_pkg: op-code localparams, flag index constants, link-register index function.
- One sub-module, dp_seq_unit: holds the counter, operand and accumulator registers and the done pulse. Shifts and optional MUL share its counter.

## Test plan
- Reset with RST_VEC=0x0100 → o_i_ad=0x0100, all flags 0, o_busy 0.
- R1=0x7FFF, R2=0x0001, ADD rd=1 rs=2 → R1=0x8000, N=1, V=1, Z=0, C=0, PC+2.
- R1=5, SUB with imm 5 → Z=1, C=1 (no borrow). Then SBC with imm 0 → R1=0, Z=1.
- R3=0x8001, SRA with imm 4 → o_busy high for exactly 4 cycles, R3=0xF800, C=0. An i_exec_ce during busy is ignored.
- i_irq_take with vector 0x0040 at PC=0x0200 → PC=0x0040, R[14]=0x0200. Same-cycle instruction not executed.
- With DATAPATH_P_MUL_EN: 0x0012×0x0034 → o_busy 16 cycles, result 0x03A8. Assert i_rst at cycle 5 → no writeback, o_busy 0 the next cycle.
